// File: rtl/cosine_vec_loader_pkg.sv
// Shared types and sizing helpers for the cosine-similarity vector loader.
package cosim_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } loader_state_t;

    // Element-index width; a single-entry bank still needs one bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/cosine_vec_loader_if.sv
// Element-in, vector-out, engine and result signals of the loader as one bundle.
interface cosine_vec_loader_if
    import cosim_pkg::*;
#(
    parameter int W = 5
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_a;
    logic [DATA_W-1:0]          in_b;
    logic                       in_last;
    logic [W-1:0][DATA_W-1:0]   vec_a;
    logic [W-1:0][DATA_W-1:0]   vec_b;
    logic                       start;
    logic                       sim_valid;
    logic [DATA_W-1:0]          sim_in;
    logic                       res_valid;
    logic                       res_ready;
    logic [DATA_W-1:0]          res_data;
    logic                       overrun;
    logic                       timeout;

    modport slave (
        input  in_valid, in_a, in_b, in_last, sim_valid, sim_in, res_ready,
        output in_ready, vec_a, vec_b, start, res_valid, res_data, overrun, timeout
    );

    modport master (
        output in_valid, in_a, in_b, in_last, sim_valid, sim_in, res_ready,
        input  in_ready, vec_a, vec_b, start, res_valid, res_data, overrun, timeout
    );
endinterface

// File: rtl/cosine_vec_bank.sv
// W x DATA_W register bank with one write port and a zero-tail clear port.
module cosine_vec_bank
    import cosim_pkg::*;
#(
    parameter int W  = 5,
    parameter int CW = cnt_w(W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [CW-1:0]            widx,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     clr,
    input  logic [CW:0]              clr_from,
    output logic [W-1:0][DATA_W-1:0] q
);

    // clr_from is always above widx when both fire, so write and clear never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (we && (widx == CW'(i)))
                    q[i] <= wdata;
                else if (clr && (clr_from <= (CW+1)'(i)))
                    q[i] <= '0;
            end
        end
    end

endmodule

// File: rtl/cosine_vec_loader.sv
// Assembles (a,b) element pairs into W-entry banks, launches the similarity engine
// and returns its result. Optional WAIT watchdog: COSIM_LOADER_TIMEOUT_EN.
module cosine_vec_loader
    import cosim_pkg::*;
#(
    parameter int W       = 5,
    parameter int TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    cosine_vec_loader_if.slave   bus
);

    localparam int CW = cnt_w(W);

    loader_state_t   state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            beat, at_end, vec_end, wd_exp;
    logic            overrun_q, timeout_q;
    logic [DATA_W-1:0] res_q;

    assign beat    = (state == FILL) && bus.in_valid;
    assign at_end  = (cnt == CW'(W-1));
    assign vec_end = beat && (bus.in_last || at_end);

`ifdef COSIM_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd_cnt;

    // Fires at the end of the TIMEOUT-th cycle spent in WAIT.
    assign wd_exp = (state == WAIT) && (wd_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wd_cnt <= '0;
        else                      wd_cnt <= wd_cnt + TW'(1);
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT;
    assign wd_exp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:   if (vec_end) state_nxt = LAUNCH;
            LAUNCH: state_nxt = WAIT;
            WAIT:   if (bus.sim_valid || wd_exp) state_nxt = HOLD;
            HOLD:   if (bus.res_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            res_q     <= '0;
        end else begin
            unique case (state)
                FILL: if (beat) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == '0)               overrun_q <= 1'b0;
                    if (at_end && !bus.in_last)  overrun_q <= 1'b1;
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    // A result arriving on the expiry cycle beats the watchdog.
                    if (bus.sim_valid) begin
                        res_q     <= bus.sim_in;
                        timeout_q <= 1'b0;
                    end else if (wd_exp) begin
                        res_q     <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                HOLD: if (bus.res_ready) timeout_q <= 1'b0;
                default: ;
            endcase
        end
    end

    logic [CW:0] clr_from;
    assign clr_from = (CW+1)'(cnt) + (CW+1)'(1);

    cosine_vec_bank #(.W(W), .CW(CW)) u_bank_a (
        .clk, .rst, .we(beat), .widx(cnt), .wdata(bus.in_a),
        .clr(vec_end), .clr_from, .q(bus.vec_a)
    );

    cosine_vec_bank #(.W(W), .CW(CW)) u_bank_b (
        .clk, .rst, .we(beat), .widx(cnt), .wdata(bus.in_b),
        .clr(vec_end), .clr_from, .q(bus.vec_b)
    );

    assign bus.in_ready  = (state == FILL);
    assign bus.start     = (state == LAUNCH);
    assign bus.res_valid = (state == HOLD);
    assign bus.res_data  = res_q;
    assign bus.overrun   = overrun_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_cosine_vec_loader.sv
// Scoreboard bench for cosine_vec_loader: expected banks/results queued at drive time.
module tb_cosine_vec_loader;
    import cosim_pkg::*;

    localparam int W  = 5;
    localparam int TO = 16;

    typedef struct {
        logic [W-1:0][DATA_W-1:0] a;
        logic [W-1:0][DATA_W-1:0] b;
        logic                     ovr;
    } vexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cosine_vec_loader_if #(.W(W)) bus ();
    cosine_vec_loader #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    vexp_t             vq[$];
    logic [DATA_W-1:0] rq[$];
    logic [DATA_W-1:0] sa[W];
    logic [DATA_W-1:0] sb[W];
    logic [DATA_W-1:0] last_res;
    int errs = 0, checks = 0, starts = 0, exp_starts = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: compare launched banks and accepted results against the queues.
    vexp_t me;
    always @(negedge clk) begin
        if (bus.start) begin
            starts++;
            if (vq.size() == 0) chk("start_unexpected", 256'(1), 256'(0));
            else begin
                me = vq.pop_front();
                chk("vec_a", 256'(bus.vec_a), 256'(me.a));
                chk("vec_b", 256'(bus.vec_b), 256'(me.b));
                chk("overrun_at_start", 256'(bus.overrun), 256'(me.ovr));
            end
        end
        if (bus.res_valid && bus.res_ready) begin
            if (rq.size() == 0) chk("res_unexpected", 256'(1), 256'(0));
            else chk("res_data_hs", 256'(bus.res_data), 256'(rq.pop_front()));
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"},  256'(bus.in_ready),  256'(1));
        chk({tag, "_start"},     256'(bus.start),     256'(0));
        chk({tag, "_res_valid"}, 256'(bus.res_valid), 256'(0));
        chk({tag, "_res_data"},  256'(bus.res_data),  256'(0));
        chk({tag, "_overrun"},   256'(bus.overrun),   256'(0));
        chk({tag, "_timeout"},   256'(bus.timeout),   256'(0));
        chk({tag, "_vec_a"},     256'(bus.vec_a),     256'(0));
        chk({tag, "_vec_b"},     256'(bus.vec_b),     256'(0));
    endtask

    // Drive n pairs from sa/sb; in_last on the final beat when 'last' is set.
    task automatic send_vec(input int n, input bit last);
        vexp_t e;
        int t;
        e.a = '0;
        e.b = '0;
        for (int i = 0; i < n; i++) begin
            e.a[i] = sa[i];
            e.b[i] = sb[i];
        end
        e.ovr = (n == W) && !last;
        vq.push_back(e);
        exp_starts++;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) chk("in_ready_wait", 256'(bus.in_ready), 256'(1));
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = sa[i];
            bus.in_b     = sb[i];
            bus.in_last  = last && (i == n - 1);
            @(posedge clk); #1;
            if (i == 0) chk("overrun_clear_first", 256'(bus.overrun), 256'(0));
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("start_after_last", 256'(bus.start), 256'(1));
        chk("in_ready_launch",  256'(bus.in_ready), 256'(0));
    endtask

    // Called in LAUNCH: step into WAIT, idle 'dly' cycles, then return 'val'.
    task automatic engine(input logic [DATA_W-1:0] val, input int dly);
        @(posedge clk); #1;
        chk("start_one_cycle", 256'(bus.start), 256'(0));
        repeat (dly) begin
            @(posedge clk); #1;
        end
        chk("in_ready_wait_state", 256'(bus.in_ready), 256'(0));
        chk("res_valid_wait_state", 256'(bus.res_valid), 256'(0));
        bus.sim_valid = 1'b1;
        bus.sim_in    = val;
        rq.push_back(val);
        last_res = val;
        @(posedge clk); #1;
        bus.sim_valid = 1'b0;
        chk("res_valid_after_sim", 256'(bus.res_valid), 256'(1));
        chk("res_data_after_sim",  256'(bus.res_data),  256'(val));
    endtask

    task automatic handshake(input int hold);
        bus.res_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("bp_res_valid", 256'(bus.res_valid), 256'(1));
            chk("bp_res_data",  256'(bus.res_data),  256'(last_res));
            chk("bp_in_ready",  256'(bus.in_ready),  256'(0));
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("fill_after_hs", 256'(bus.in_ready), 256'(1));
        chk("res_valid_after_hs", 256'(bus.res_valid), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.sim_valid = 1'b0;
        bus.sim_in    = '0;
        bus.res_ready = 1'b0;
        last_res      = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("rst");

        // Full vector, immediate result
        for (int i = 0; i < W; i++) begin
            sa[i] = DATA_W'(i + 1);
            sb[i] = DATA_W'(W - i);
        end
        send_vec(W, 1'b1);
        engine(32'h3F4C_CCCD, 0);
        handshake(0);

        // Short vector zero-pads the tail
        sa[0] = 7; sa[1] = 8; sa[2] = 9;
        sb[0] = 1; sb[1] = 1; sb[2] = 1;
        send_vec(3, 1'b1);
        engine(32'h1234_5678, 2);
        handshake(1);

        // Overrun: W beats with no in_last, then a fresh vector clears it
        for (int i = 0; i < W; i++) begin
            sa[i] = DATA_W'(32'h100 + i);
            sb[i] = DATA_W'(32'h200 + i);
        end
        send_vec(W, 1'b0);
        engine(32'hDEAD_0001, 1);
        handshake(0);
        sa[0] = 32'hA; sa[1] = 32'hB;
        sb[0] = 32'hC; sb[1] = 32'hD;
        send_vec(2, 1'b1);
        engine(32'hBEEF_0002, 0);
        // Backpressure in HOLD
        handshake(4);

        // Reset while in WAIT, then a stale engine result
        send_vec(4, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset("rst_wait");
        bus.sim_valid = 1'b1;
        bus.sim_in    = 32'hCAFE_CAFE;
        @(posedge clk); #1;
        bus.sim_valid = 1'b0;
        repeat (3) begin
            chk("stale_sim_ignored", 256'(bus.res_valid), 256'(0));
            @(posedge clk); #1;
        end

        // Randomised vectors
        for (int k = 0; k < 6; k++) begin
            int n;
            bit lst;
            n   = $urandom_range(1, W);
            lst = (n < W) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < W; i++) begin
                sa[i] = $urandom;
                sb[i] = $urandom;
            end
            send_vec(n, lst);
            engine($urandom, $urandom_range(0, 3));
            handshake($urandom_range(0, 2));
        end

`ifdef COSIM_LOADER_TIMEOUT_EN
        sa[0] = 3; sa[1] = 4; sa[2] = 5;
        sb[0] = 6; sb[1] = 7; sb[2] = 8;
        send_vec(3, 1'b1);
        repeat (TO) begin
            @(posedge clk); #1;
        end
        chk("wd_not_yet", 256'(bus.res_valid), 256'(0));
        @(posedge clk); #1;
        chk("wd_res_valid", 256'(bus.res_valid), 256'(1));
        chk("wd_res_data",  256'(bus.res_data),  256'(0));
        chk("wd_timeout",   256'(bus.timeout),   256'(1));
        rq.push_back('0);
        last_res = '0;
        handshake(1);
        chk("wd_timeout_clear", 256'(bus.timeout), 256'(0));
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("start_count", 256'(starts), 256'(exp_starts));
        chk("vq_drained", 256'(vq.size()), 256'(0));
        chk("rq_drained", 256'(rq.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
